button_debounce_bank: RTL



---
 rtl/button_debounce_bank_pkg.sv | 31 +++
 rtl/button_debounce_bank_channel.sv | 167 ++++++++++++++++
 rtl/button_debounce_bank.sv | 54 +++++
 3 files changed

// File: rtl/button_debounce_bank_pkg.sv
// Shared definitions for the push-button debounce bank: channel state
// encoding, button index constants and the default debounce length.
package btn_pkg;

    // Channel FSM states. Bit 1 set means the debounced level is high
    // (PRESSED and RELEASE_PEND both report the button as held).
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_e;

    // Plain-vector aliases used inside the FSM logic.
    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_PEND   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_PEND = 2'd3;

    // Button positions on ui_in[5:0].
    localparam int BTN_D4   = 0;
    localparam int BTN_D6   = 1;
    localparam int BTN_D8   = 2;
    localparam int BTN_D10  = 3;
    localparam int BTN_D20  = 4;
    localparam int BTN_D100 = 5;

    // About 10 ms at 32768 Hz.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 328;

endpackage

// File: rtl/button_debounce_bank_channel.sv
// One debounce channel: 2-flop synchroniser, 4-state stability FSM with a
// sample counter, and (with DEBOUNCE_AUTOREPEAT_EN defined) a hold counter
// that re-issues press pulses while the button stays down.
// The FSM state is exported so the bank can derive the level from it and
// so checkers can observe it directly.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = 16384,
    parameter int REPEAT_PERIOD   = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw,
    output logic [1:0] state,
    output logic       press,
    output logic       release_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Reject parameter values the counter logic cannot honour.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 4095 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("debounce_channel: illegal parameter value");
    end

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [1:0]    state_nxt;
    logic          press_nxt;
    logic          release_nxt;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] HOLD_DELAY_LAST  = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] HOLD_PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

    logic [HW-1:0] hold;
    logic [HW-1:0] hold_nxt;
    logic          repeating;
    logic          repeating_nxt;
`endif

    // Two-flop synchroniser; only s2 is allowed to reach the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Next-state logic: a level change is accepted only after the
    // synchronised input has held its new value for DEBOUNCE_CYCLES samples.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        hold_nxt      = hold;
        repeating_nxt = repeating;
`endif
        case (state)
            ST_RELEASED: begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
                hold_nxt      = '0;
                repeating_nxt = 1'b0;
`endif
                if (s2) begin
                    state_nxt = ST_PRESS_PEND;
                    cnt_nxt   = CW'(1);
                end else begin
                    cnt_nxt = '0;
                end
            end
            ST_PRESS_PEND: begin
                if (!s2) begin
                    state_nxt = ST_RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_PRESSED;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                    hold_nxt      = '0;
                    repeating_nxt = 1'b0;
`endif
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_PRESSED: begin
                if (!s2) begin
                    // Hold counter is left untouched: it freezes while the
                    // release is being qualified.
                    state_nxt = ST_RELEASE_PEND;
                    cnt_nxt   = CW'(1);
                end else begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
                    // First repeat after REPEAT_DELAY, then every REPEAT_PERIOD.
                    if ((!repeating && hold == HOLD_DELAY_LAST) ||
                        ( repeating && hold == HOLD_PERIOD_LAST)) begin
                        press_nxt     = 1'b1;
                        hold_nxt      = '0;
                        repeating_nxt = 1'b1;
                    end else begin
                        hold_nxt = hold + HW'(1);
                    end
`endif
                end
            end
            ST_RELEASE_PEND: begin
                if (s2) begin
                    state_nxt = ST_PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = ST_RELEASED;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = ST_RELEASED;
                cnt_nxt   = '0;
            end
        endcase
    end

    // FSM, counter and registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_RELEASED;
            cnt           <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            press         <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    // Hold counter and first-repeat flag for auto-repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= '0;
            repeating <= 1'b0;
        end else begin
            hold      <= hold_nxt;
            repeating <= repeating_nxt;
        end
    end
`endif

endmodule

// File: rtl/button_debounce_bank.sv
// Debounce bank for the dice push-buttons (ui_in[5:0]). Each button gets an
// independent debounce_channel; the bank collects clean levels, one-cycle
// press/release pulses and an any-press strobe for the digit counter.
// Optional build macro: DEBOUNCE_AUTOREPEAT_EN (press auto-repeat while held).
module button_debounce_bank
    import btn_pkg::*;
#(
    parameter int NUM_BTN         = 6,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = 16384,
    parameter int REPEAT_PERIOD   = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               any_press
);

    logic [1:0] chan_state [NUM_BTN];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .raw           (btn_raw[i]),
            .state         (chan_state[i]),
            .press         (btn_press[i]),
            .release_pulse (btn_release[i])
        );
    end

    // Debounced level is high in PRESSED and RELEASE_PEND; this is a decode
    // of registered state, so it changes on the same edge as the press pulse.
    always_comb begin
        btn_level = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            btn_level[i] = (chan_state[i] == ST_PRESSED) ||
                           (chan_state[i] == ST_RELEASE_PEND);
        end
    end

    // Combined strobe straight from the registered press pulses.
    always_comb begin
        any_press = |btn_press;
    end

endmodule
